word_serdes: RTL and testbench
==============================

WORD_SERDES -- requirements
Module: word_serdes

Interface
REQ-001 The parameter DATA_W SHALL default to 16 and is the parallel word width in bits.
REQ-002 The parameter CHUNK_W SHALL default to 8 and is the serial chunk width; N = DATA_W/CHUNK_W, integer and >= 2 (elaboration error otherwise).
REQ-003 The parameter CHECK_OPCODE SHALL default to 1; when 1, enables the opcode legality check on assembled words.
REQ-004 clk input 1 SHALL be the clock; all state changes on its rising edge.
REQ-005 rst input 1 SHALL be the reset: synchronous, active-high.
REQ-006 The RX chunk inputs SHALL be in_valid (input, 1), in_chunk (input, CHUNK_W) and in_ready (output, 1).
REQ-007 The RX word outputs SHALL be word_valid (output, 1), word_out (output, DATA_W) and word_err (output, 1); word_ready (input, 1) is the consumer handshake.
REQ-008 rx_flush input 1 SHALL discard any partially assembled RX word.
REQ-009 The TX load port SHALL be load_valid (input, 1), load_data (input, DATA_W) and load_ready (output, 1).
REQ-010 The TX chunk outputs SHALL be out_valid (output, 1), out_chunk (output, CHUNK_W) and out_last (output, 1); out_ready (input, 1) is the consumer handshake.

Function
REQ-011 Handshakes SHALL be valid/ready: a transfer occurs in a cycle where both valid and ready are high. A producer may not withdraw valid before transfer.
REQ-012 The RX FSM SHALL have states FILL and FULL. It holds a chunk counter rx_cnt of width clog2(N) and a DATA_W shift register.
REQ-013 In FILL, in_ready SHALL be 1. Each RX transfer performs shift <= {shift[DATA_W-CHUNK_W-1:0], in_chunk} and rx_cnt++ (first chunk ends in the MSBs).
REQ-014 An RX transfer with rx_cnt == N-1 SHALL move the FSM to FULL next cycle with rx_cnt = 0. word_valid asserts that cycle, giving 1 cycle latency from the last chunk.
REQ-015 In FULL: in_ready SHALL be 0, word_valid 1, and word_out/word_err stable. A word_ready transfer returns to FILL; no back-to-back overlap, so the first new chunk is accepted one cycle later at the earliest.
REQ-016 word_err SHALL be 1 only when word_valid=1, CHECK_OPCODE=1, and word_out[2:0] is not one of R_TYPE, I_TYPE, B_TYPE, J_TYPE, M_TYPE (team opcode_t). The word is still delivered; error does not block the handshake.
REQ-017 rx_flush in FILL SHALL clear rx_cnt and the shift register next cycle, and any in_valid chunk that same cycle is dropped. rx_flush in FULL SHALL be ignored.
REQ-018 The TX FSM SHALL have states IDLE and SHIFT, a counter tx_cnt (clog2(N) bits) and a DATA_W register.
REQ-019 In IDLE, load_ready SHALL be 1 and out_valid 0. A load transfer latches load_data and enters SHIFT with tx_cnt=0.
REQ-020 In SHIFT, out_valid SHALL be 1, out_chunk = register[DATA_W-1 -: CHUNK_W] (MSB chunk first), and out_last = (tx_cnt == N-1).
REQ-021 Each TX transfer SHALL shift the register left by CHUNK_W (zero fill) and increment tx_cnt. A transfer with out_last=1 returns to IDLE with tx_cnt=0.
REQ-022 In SHIFT, load_ready SHALL be 0 and load_valid is ignored; a stalled out_ready holds all TX outputs stable indefinitely.
REQ-023 The RX and TX paths SHALL be fully independent; simultaneous activity on both in any cycle is legal.
REQ-024 No combinational path SHALL exist from word_ready/out_ready to in_ready/load_ready within the same cycle; all ready outputs are state-decoded.

Reset
REQ-025 While rst=1 (regardless of other inputs): RX in FILL, rx_cnt=0, shift=0. TX in IDLE, tx_cnt=0, register=0.
REQ-026 During and on the cycle after reset, outputs SHALL be: in_ready=1, word_valid=0, word_out=0, word_err=0, load_ready=1, out_valid=0, out_chunk=0, out_last=0.
REQ-027 Reset asserted mid-word (RX partial or TX SHIFT) SHALL abandon the word with no further handshakes.

Verification
REQ-028 Defaults: feed chunks 0x12 then 0x08 with word_ready=1 -> word_valid one cycle after 2nd chunk, word_out=0x1208, word_err follows opcode 3'b000 legality.
REQ-029 Feed 0xAB, 0xCD, with word_ready held 0 for 5 cycles -> word_valid stays 1, in_ready=0, word_out=0xABCD stable. A further in_valid chunk 0xEE is not accepted.
REQ-030 Feed 0x34 then rx_flush with in_valid=1, in_chunk=0x56 -> 0x56 dropped. Then 0x9A, 0xBC -> word_out=0x9ABC.
REQ-031 Load 0xBEEF with out_ready toggling 1,0,1 -> chunks 0xBE (out_last=0), 0xEF (out_last=1), then load_ready=1.
REQ-032 DATA_W=32, CHUNK_W=8, CHECK_OPCODE=0: RX 0x11,0x22,0x33,0x47 -> word_out=0x11223347, word_err=0. TX 0xCAFEF00D -> CA,FE,F0,0D, out_last on 0D only.
REQ-033 rst asserted with RX holding 1 chunk and TX mid-shift -> next cycle all REQ-026 values, then a fresh full word assembles correctly.

Source files
------------

// File: rtl/word_serdes.sv
// Word serializer/deserializer: RX packs CHUNK_W-bit chunks into DATA_W-bit words (MSB chunk
// first) with an optional opcode legality flag; TX splits DATA_W-bit words back into chunks.
module word_serdes #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CHUNK_W      = 8,
    parameter bit          CHECK_OPCODE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    // RX chunk side
    input  logic               in_valid,
    input  logic [CHUNK_W-1:0] in_chunk,
    output logic               in_ready,
    // RX word side
    output logic               word_valid,
    output logic [DATA_W-1:0]  word_out,
    output logic               word_err,
    input  logic               word_ready,
    input  logic               rx_flush,
    // TX load side
    input  logic               load_valid,
    input  logic [DATA_W-1:0]  load_data,
    output logic               load_ready,
    // TX chunk side
    output logic               out_valid,
    output logic [CHUNK_W-1:0] out_chunk,
    output logic               out_last,
    input  logic               out_ready
);

    localparam int unsigned N     = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    generate
        if ((DATA_W % CHUNK_W) != 0 || N < 2) begin : g_bad_params
            $error("word_serdes: DATA_W must be an integer multiple (>= 2) of CHUNK_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        R_TYPE = 3'b000,
        I_TYPE = 3'b001,
        B_TYPE = 3'b010,
        J_TYPE = 3'b011,
        M_TYPE = 3'b100
    } opcode_t;

    typedef enum logic {RxFill, RxFull} rx_state_t;
    typedef enum logic {TxIdle, TxShift} tx_state_t;

    rx_state_t          r_rx_state;
    logic [CNT_W-1:0]   r_rx_cnt;
    logic [DATA_W-1:0]  r_shift;

    tx_state_t          r_tx_state;
    logic [CNT_W-1:0]   r_tx_cnt;
    logic [DATA_W-1:0]  r_tx;

    logic               w_op_legal;

    // RX: flush takes priority over a same-cycle chunk, which is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RxFill;
            r_rx_cnt   <= '0;
            r_shift    <= '0;
        end else if (r_rx_state == RxFill) begin
            if (rx_flush) begin
                r_rx_cnt <= '0;
                r_shift  <= '0;
            end else if (in_valid) begin
                r_shift <= {r_shift[DATA_W-CHUNK_W-1:0], in_chunk};
                if (r_rx_cnt == LAST_CNT) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= RxFull;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end
        end else if (word_ready) begin
            r_rx_state <= RxFill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TxIdle;
            r_tx_cnt   <= '0;
            r_tx       <= '0;
        end else if (r_tx_state == TxIdle) begin
            if (load_valid) begin
                r_tx       <= load_data;
                r_tx_cnt   <= '0;
                r_tx_state <= TxShift;
            end
        end else if (out_ready) begin
            r_tx <= {r_tx[DATA_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
            if (r_tx_cnt == LAST_CNT) begin
                r_tx_cnt   <= '0;
                r_tx_state <= TxIdle;
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_op_legal = 1'b0;
        case (r_shift[2:0])
            R_TYPE, I_TYPE, B_TYPE, J_TYPE, M_TYPE: w_op_legal = 1'b1;
            default:                                w_op_legal = 1'b0;
        endcase
    end

    // Ready outputs decode state only, so no path from the downstream readies.
    assign in_ready   = (r_rx_state == RxFill);
    assign word_valid = (r_rx_state == RxFull);
    assign word_out   = r_shift;
    assign word_err   = word_valid && CHECK_OPCODE && !w_op_legal;

    assign load_ready = (r_tx_state == TxIdle);
    assign out_valid  = (r_tx_state == TxShift);
    assign out_chunk  = r_tx[DATA_W-1 -: CHUNK_W];
    assign out_last   = out_valid && (r_tx_cnt == LAST_CNT);

endmodule

// File: tb/tb_word_serdes.sv
// Bench for word_serdes: a 16/8 checked instance and a 32/8 unchecked instance, each with a
// queue-based reference model of the chunk/word streams and independent output monitors.
module tb_word_serdes;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: DATA_W=16, CHUNK_W=8, CHECK_OPCODE=1
    logic        a_in_valid = 0, a_word_ready = 0, a_rx_flush = 0, a_load_valid = 0, a_out_ready = 0;
    logic [7:0]  a_in_chunk = 0;
    logic [15:0] a_load_data = 0;
    logic        a_in_ready, a_word_valid, a_word_err, a_load_ready, a_out_valid, a_out_last;
    logic [15:0] a_word_out;
    logic [7:0]  a_out_chunk;

    // Instance B: DATA_W=32, CHUNK_W=8, CHECK_OPCODE=0
    logic        b_in_valid = 0, b_word_ready = 0, b_rx_flush = 0, b_load_valid = 0, b_out_ready = 0;
    logic [7:0]  b_in_chunk = 0;
    logic [31:0] b_load_data = 0;
    logic        b_in_ready, b_word_valid, b_word_err, b_load_ready, b_out_valid, b_out_last;
    logic [31:0] b_word_out;
    logic [7:0]  b_out_chunk;

    word_serdes #(.DATA_W(16), .CHUNK_W(8), .CHECK_OPCODE(1'b1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_chunk(a_in_chunk), .in_ready(a_in_ready),
        .word_valid(a_word_valid), .word_out(a_word_out), .word_err(a_word_err),
        .word_ready(a_word_ready), .rx_flush(a_rx_flush),
        .load_valid(a_load_valid), .load_data(a_load_data), .load_ready(a_load_ready),
        .out_valid(a_out_valid), .out_chunk(a_out_chunk), .out_last(a_out_last),
        .out_ready(a_out_ready)
    );

    word_serdes #(.DATA_W(32), .CHUNK_W(8), .CHECK_OPCODE(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_chunk(b_in_chunk), .in_ready(b_in_ready),
        .word_valid(b_word_valid), .word_out(b_word_out), .word_err(b_word_err),
        .word_ready(b_word_ready), .rx_flush(b_rx_flush),
        .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
        .out_valid(b_out_valid), .out_chunk(b_out_chunk), .out_last(b_out_last),
        .out_ready(b_out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Legal opcodes are R/I/B/J/M encoded 0..4.
    function automatic bit op_ok(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

    // ---------------- reference model: RX ----------------
    logic [7:0]  a_part[$];
    logic [7:0]  b_part[$];
    logic [16:0] a_wq[$];
    logic [32:0] b_wq[$];
    bit          a_pend = 0, b_pend = 0;
    logic [15:0] a_w;
    logic [31:0] b_w;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            a_part.delete(); a_wq.delete(); a_pend = 0;
        end else begin
            chk("a_in_ready", a_in_ready, !a_pend);
            chk("a_word_valid", a_word_valid, a_pend);
            if (a_pend) begin
                if (a_word_ready) a_pend = 0;
            end else if (a_rx_flush) begin
                a_part.delete();
            end else if (a_in_valid) begin
                a_part.push_back(a_in_chunk);
                if (a_part.size() == 2) begin
                    a_w = '0;
                    foreach (a_part[i]) a_w = (a_w << 8) | 16'(a_part[i]);
                    a_wq.push_back({!op_ok(a_w[2:0]), a_w});
                    a_part.delete();
                    a_pend = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            b_part.delete(); b_wq.delete(); b_pend = 0;
        end else begin
            chk("b_in_ready", b_in_ready, !b_pend);
            chk("b_word_valid", b_word_valid, b_pend);
            if (b_pend) begin
                if (b_word_ready) b_pend = 0;
            end else if (b_rx_flush) begin
                b_part.delete();
            end else if (b_in_valid) begin
                b_part.push_back(b_in_chunk);
                if (b_part.size() == 4) begin
                    b_w = '0;
                    foreach (b_part[i]) b_w = (b_w << 8) | 32'(b_part[i]);
                    b_wq.push_back({1'b0, b_w});
                    b_part.delete();
                    b_pend = 1;
                end
            end
        end
    end

    // ---------------- word monitors ----------------
    logic [16:0] a_we;
    logic [32:0] b_we;

    initial forever begin
        @(negedge clk);
        if (!rst && a_word_valid && a_word_ready) begin
            if (a_wq.size() == 0) chk("a_word_unexpected", a_word_valid, 1'b0);
            else begin
                a_we = a_wq.pop_front();
                chk("a_word_out", a_word_out, a_we[15:0]);
                chk("a_word_err", a_word_err, a_we[16]);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && b_word_valid && b_word_ready) begin
            if (b_wq.size() == 0) chk("b_word_unexpected", b_word_valid, 1'b0);
            else begin
                b_we = b_wq.pop_front();
                chk("b_word_out", b_word_out, b_we[31:0]);
                chk("b_word_err", b_word_err, b_we[32]);
            end
        end
    end

    // ---------------- TX: expected chunk queues and monitors ----------------
    logic [8:0] a_tq[$];
    logic [8:0] b_tq[$];
    bit         a_tx_busy = 0, b_tx_busy = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            a_tq.delete(); a_tx_busy = 0;
        end else begin
            a_tx_busy = (a_tq.size() != 0);
            chk("a_load_ready", a_load_ready, !a_tx_busy);
            chk("a_out_valid", a_out_valid, a_tx_busy);
            if (a_tx_busy) begin
                chk("a_out_chunk", a_out_chunk, a_tq[0][7:0]);
                chk("a_out_last", a_out_last, a_tq[0][8]);
                if (a_out_ready) void'(a_tq.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            b_tq.delete(); b_tx_busy = 0;
        end else begin
            b_tx_busy = (b_tq.size() != 0);
            chk("b_load_ready", b_load_ready, !b_tx_busy);
            chk("b_out_valid", b_out_valid, b_tx_busy);
            if (b_tx_busy) begin
                chk("b_out_chunk", b_out_chunk, b_tq[0][7:0]);
                chk("b_out_last", b_out_last, b_tq[0][8]);
                if (b_out_ready) void'(b_tq.pop_front());
            end
        end
    end

    // Loads are recorded just after the monitors have decided whether TX was busy.
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst && !a_tx_busy && a_load_valid)
            for (int k = 0; k < 2; k++)
                a_tq.push_back({1'(k == 1), 8'(a_load_data >> (8 * (1 - k)))});
        if (!rst && !b_tx_busy && b_load_valid)
            for (int k = 0; k < 4; k++)
                b_tq.push_back({1'(k == 3), 8'(b_load_data >> (8 * (3 - k)))});
    end

    // ---------------- stimulus helpers (enter and leave at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_send(input logic [7:0] c);
        int n = 0;
        a_in_valid = 1; a_in_chunk = c;
        do begin @(negedge clk); n++; end while (!a_in_ready && n < 50);
        if (!a_in_ready) chk("a_send_timeout", a_in_ready, 1'b1);
        tick(1);
        a_in_valid = 0;
    endtask

    task automatic b_send(input logic [7:0] c);
        int n = 0;
        b_in_valid = 1; b_in_chunk = c;
        do begin @(negedge clk); n++; end while (!b_in_ready && n < 50);
        if (!b_in_ready) chk("b_send_timeout", b_in_ready, 1'b1);
        tick(1);
        b_in_valid = 0;
    endtask

    task automatic a_load(input logic [15:0] d);
        int n = 0;
        a_load_valid = 1; a_load_data = d;
        do begin @(negedge clk); n++; end while (!a_load_ready && n < 50);
        if (!a_load_ready) chk("a_load_timeout", a_load_ready, 1'b1);
        tick(1);
        a_load_valid = 0;
    endtask

    task automatic b_load(input logic [31:0] d);
        int n = 0;
        b_load_valid = 1; b_load_data = d;
        do begin @(negedge clk); n++; end while (!b_load_ready && n < 50);
        if (!b_load_ready) chk("b_load_timeout", b_load_ready, 1'b1);
        tick(1);
        b_load_valid = 0;
    endtask

    task automatic a_chk_reset(input string tag);
        chk({tag, "_in_ready"}, a_in_ready, 1'b1);
        chk({tag, "_word_valid"}, a_word_valid, 1'b0);
        chk({tag, "_word_out"}, a_word_out, 16'h0);
        chk({tag, "_word_err"}, a_word_err, 1'b0);
        chk({tag, "_load_ready"}, a_load_ready, 1'b1);
        chk({tag, "_out_valid"}, a_out_valid, 1'b0);
        chk({tag, "_out_chunk"}, a_out_chunk, 8'h0);
        chk({tag, "_out_last"}, a_out_last, 1'b0);
    endtask

    bit tk_rx, tk_ld;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        rst = 0;
        a_chk_reset("rst0");

        // Two-chunk word, opcode 000 is legal.
        a_word_ready = 1;
        a_send(8'h12);
        a_send(8'h08);
        chk("r028_valid", a_word_valid, 1'b1);
        chk("r028_word", a_word_out, 16'h1208);
        chk("r028_err", a_word_err, 1'b0);
        tick(2);

        // Consumer stall: word held, new chunk refused; opcode 101 is illegal.
        a_word_ready = 0;
        a_send(8'hAB);
        a_send(8'hCD);
        a_in_valid = 1; a_in_chunk = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            chk("r029_valid", a_word_valid, 1'b1);
            chk("r029_in_ready", a_in_ready, 1'b0);
            chk("r029_word", a_word_out, 16'hABCD);
            chk("r029_err", a_word_err, 1'b1);
            tick(1);
        end
        a_word_ready = 1;
        a_send(8'hEE);
        a_send(8'h01);
        chk("r029_next_word", a_word_out, 16'hEE01);
        tick(2);

        // Flush drops the partial word and the same-cycle chunk.
        a_send(8'h34);
        a_rx_flush = 1; a_in_valid = 1; a_in_chunk = 8'h56;
        tick(1);
        a_rx_flush = 0; a_in_valid = 0;
        a_send(8'h9A);
        a_send(8'hBC);
        chk("r030_word", a_word_out, 16'h9ABC);
        chk("r030_err", a_word_err, 1'b0);
        tick(2);

        // TX with a stall on the last chunk.
        a_out_ready = 0;
        a_load(16'hBEEF);
        a_out_ready = 1;
        chk("r031_c0", a_out_chunk, 8'hBE); chk("r031_l0", a_out_last, 1'b0);
        tick(1);
        a_out_ready = 0;
        chk("r031_c1", a_out_chunk, 8'hEF); chk("r031_l1", a_out_last, 1'b1);
        tick(1);
        a_out_ready = 1;
        chk("r031_c1_hold", a_out_chunk, 8'hEF); chk("r031_l1_hold", a_out_last, 1'b1);
        tick(1);
        chk("r031_load_ready", a_load_ready, 1'b1);
        chk("r031_out_valid", a_out_valid, 1'b0);

        // Wide instance without opcode check; opcode 111 would otherwise be illegal.
        b_word_ready = 1; b_out_ready = 1;
        b_send(8'h11); b_send(8'h22); b_send(8'h33); b_send(8'h47);
        chk("r032_word", b_word_out, 32'h11223347);
        chk("r032_err", b_word_err, 1'b0);
        tick(1);
        b_load(32'hCAFEF00D);
        chk("r032_c0", b_out_chunk, 8'hCA); chk("r032_l0", b_out_last, 1'b0); tick(1);
        chk("r032_c1", b_out_chunk, 8'hFE); chk("r032_l1", b_out_last, 1'b0); tick(1);
        chk("r032_c2", b_out_chunk, 8'hF0); chk("r032_l2", b_out_last, 1'b0); tick(1);
        chk("r032_c3", b_out_chunk, 8'h0D); chk("r032_l3", b_out_last, 1'b1); tick(1);
        chk("r032_load_ready", b_load_ready, 1'b1);

        // Reset with RX partial and TX mid-shift.
        a_in_valid = 1; a_in_chunk = 8'h55;
        a_load_valid = 1; a_load_data = 16'h1234; a_out_ready = 0;
        tick(1);
        a_in_valid = 0; a_load_valid = 0; a_out_ready = 1;
        tick(1);
        a_out_ready = 0;
        rst = 1;
        tick(1);
        rst = 0;
        a_chk_reset("r033");
        a_send(8'h21);
        a_send(8'h43);
        chk("r033_word", a_word_out, 16'h2143);
        chk("r033_err", a_word_err, 1'b0);
        tick(2);

        // Randomized traffic on A; valids are held until accepted.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            tk_rx = a_in_valid && a_in_ready;
            tk_ld = a_load_valid && a_load_ready;
            @(posedge clk);
            #1;
            if (!a_in_valid || tk_rx) begin
                a_in_valid = ($urandom_range(2) != 0);
                a_in_chunk = 8'($urandom);
            end
            if (!a_load_valid || tk_ld) begin
                a_load_valid = ($urandom_range(3) == 0);
                a_load_data  = 16'($urandom);
            end
            a_word_ready = ($urandom_range(3) != 0);
            a_out_ready  = ($urandom_range(2) != 0);
            a_rx_flush   = ($urandom_range(15) == 0);
        end

        // Drain: finish any in-flight load before dropping load_valid.
        @(negedge clk);
        tk_ld = a_load_valid && a_load_ready;
        @(posedge clk);
        #1;
        if (tk_ld || !a_load_ready) a_load_valid = 0;
        a_in_valid = 0; a_rx_flush = 0; a_word_ready = 1; a_out_ready = 1;
        tick(2);
        a_load_valid = 0;
        tick(10);
        chk("a_words_pending", a_wq.size(), 0);
        chk("a_chunks_pending", a_tq.size(), 0);
        chk("b_words_pending", b_wq.size(), 0);
        chk("b_chunks_pending", b_tq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
